// File: rtl/dpram_pkg.sv
// rtl/dpram_pkg.sv - shared types, constants and parity helper for the dual-port RAM
package dpram_pkg;

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_t;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    // Even parity over a zero-extended word; zero padding does not change the result.
    function automatic logic parity(input logic [63:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/dual_port_ram_param_if.sv
// rtl/dual_port_ram_param_if.sv - port bundle for dual_port_ram_param (perr_a/perr_b under DPRAM_PARITY_EN)
interface dual_port_ram_param_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    logic              init_busy;
    logic              en_a;
    logic              we_a;
    logic [ADDR_W-1:0] addr_a;
    logic [DATA_W-1:0] din_a;
    logic [DATA_W-1:0] dout_a;
    logic              rvalid_a;
    logic              en_b;
    logic              we_b;
    logic [ADDR_W-1:0] addr_b;
    logic [DATA_W-1:0] din_b;
    logic [DATA_W-1:0] dout_b;
    logic              rvalid_b;
    logic              collision;
`ifdef DPRAM_PARITY_EN
    logic              perr_a;
    logic              perr_b;
`endif

    modport master (
        output en_a, we_a, addr_a, din_a,
        output en_b, we_b, addr_b, din_b,
`ifdef DPRAM_PARITY_EN
        input  perr_a, perr_b,
`endif
        input  init_busy, dout_a, rvalid_a, dout_b, rvalid_b, collision
    );

    modport slave (
        input  en_a, we_a, addr_a, din_a,
        input  en_b, we_b, addr_b, din_b,
`ifdef DPRAM_PARITY_EN
        output perr_a, perr_b,
`endif
        output init_busy, dout_a, rvalid_a, dout_b, rvalid_b, collision
    );

endinterface

// File: rtl/dpram_out_stage.sv
// rtl/dpram_out_stage.sv - per-port read data/valid register with optional second stage
module dpram_out_stage #(
    parameter int W       = 8,
    parameter int OUT_REG = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         rvalid
);

    logic         v1;
    logic [W-1:0] d1;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
            d1 <= '0;
        end else begin
            v1 <= req;
            if (req) d1 <= din;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_reg
            logic         v2;
            logic [W-1:0] d2;

            always_ff @(posedge clk) begin
                if (rst) begin
                    v2 <= 1'b0;
                    d2 <= '0;
                end else begin
                    v2 <= v1;
                    if (v1) d2 <= d1;
                end
            end

            assign dout   = d2;
            assign rvalid = v2;
        end else begin : g_direct
            assign dout   = d1;
            assign rvalid = v1;
        end
    endgenerate

endmodule

// File: rtl/dual_port_ram_param.sv
// rtl/dual_port_ram_param.sv - true dual-port RAM with clear sequencer; DPRAM_PARITY_EN adds per-word parity
module dual_port_ram_param
    import dpram_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter int RDW_MODE = 0,
    parameter int OUT_REG  = 0
) (
    input logic                clk,
    input logic                rst,
    dual_port_ram_param_if.slave bus
);

    localparam int DEPTH = 2 ** ADDR_W;
`ifdef DPRAM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] clr_ptr;
    logic [MEM_W-1:0]  mem [DEPTH];

    logic              active;
    logic              wr_a, rd_a, wr_b, rd_b, same_addr;
    logic [MEM_W-1:0]  word_a, word_b, rdata_a, rdata_b;
    logic [MEM_W-1:0]  pay_a, pay_b, out_a, out_b;
    logic              rv_a, rv_b;
    logic              coll_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_CLEAR;
            clr_ptr <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_CLEAR) clr_ptr <= clr_ptr + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == ST_CLEAR && clr_ptr == ADDR_W'(DEPTH - 1)) state_nxt = ST_RUN;
    end

    // Requests only count in RUN and never on a reset edge.
    assign active    = (state == ST_RUN) && !rst;
    assign wr_a      = active && bus.en_a && bus.we_a;
    assign rd_a      = active && bus.en_a && !bus.we_a;
    assign wr_b      = active && bus.en_b && bus.we_b;
    assign rd_b      = active && bus.en_b && !bus.we_b;
    assign same_addr = (bus.addr_a == bus.addr_b);

`ifdef DPRAM_PARITY_EN
    assign word_a = {parity(64'(bus.din_a)), bus.din_a};
    assign word_b = {parity(64'(bus.din_b)), bus.din_b};
`else
    assign word_a = bus.din_a;
    assign word_b = bus.din_b;
`endif

    // Port A wins a same-address write/write; port B's data is dropped.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == ST_CLEAR) begin
                mem[clr_ptr] <= '0;
            end else begin
                if (wr_a) mem[bus.addr_a] <= word_a;
                if (wr_b && !(wr_a && same_addr)) mem[bus.addr_b] <= word_b;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) coll_q <= 1'b0;
        else     coll_q <= wr_a && wr_b && same_addr;
    end

    assign rdata_a = (RDW_MODE == RDW_NEW && wr_b && same_addr) ? word_b : mem[bus.addr_a];
    assign rdata_b = (RDW_MODE == RDW_NEW && wr_a && same_addr) ? word_a : mem[bus.addr_b];

    // With parity the top bit of the payload carries the mismatch flag, not the stored bit.
`ifdef DPRAM_PARITY_EN
    assign pay_a = {parity(64'(rdata_a[DATA_W-1:0])) ^ rdata_a[DATA_W], rdata_a[DATA_W-1:0]};
    assign pay_b = {parity(64'(rdata_b[DATA_W-1:0])) ^ rdata_b[DATA_W], rdata_b[DATA_W-1:0]};
`else
    assign pay_a = rdata_a;
    assign pay_b = rdata_b;
`endif

    dpram_out_stage #(.W(MEM_W), .OUT_REG(OUT_REG)) u_out_a (
        .clk    (clk),
        .rst    (rst),
        .req    (rd_a),
        .din    (pay_a),
        .dout   (out_a),
        .rvalid (rv_a)
    );

    dpram_out_stage #(.W(MEM_W), .OUT_REG(OUT_REG)) u_out_b (
        .clk    (clk),
        .rst    (rst),
        .req    (rd_b),
        .din    (pay_b),
        .dout   (out_b),
        .rvalid (rv_b)
    );

    assign bus.init_busy = (state == ST_CLEAR);
    assign bus.collision = coll_q;
    assign bus.dout_a    = out_a[DATA_W-1:0];
    assign bus.dout_b    = out_b[DATA_W-1:0];
    assign bus.rvalid_a  = rv_a;
    assign bus.rvalid_b  = rv_b;
`ifdef DPRAM_PARITY_EN
    assign bus.perr_a    = rv_a && out_a[DATA_W];
    assign bus.perr_b    = rv_b && out_b[DATA_W];
`endif

endmodule

// File: doc/dual_port_ram_param.md
Name: dual_port_ram_param

Overview:
Parametrised true dual-port synchronous RAM: two independent read/write ports on one clock, configurable width and depth. Adds over the previous fixed 8x8 RAM: explicit port enables, read-valid strobes, optional output pipeline register, defined same-address collision policy, and a post-reset clear sequencer. Used as the generic shared-buffer primitive for the memory subsystem.

Parameters:
DATA_W, 8, word width in bits (>=1)
ADDR_W, 3, address width; DEPTH = 2**ADDR_W words
RDW_MODE, 0, cross-port read-during-write to same address: 0 = old data, 1 = new data
OUT_REG, 0, 1 = extra output register stage (read latency 2 instead of 1)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
init_busy  output  1  high while clear sequencer runs; port requests ignored
en_a  input  1  port A request
we_a  input  1  port A write (1) / read (0), qualified by en_a
addr_a  input  ADDR_W  port A address
din_a  input  DATA_W  port A write data
dout_a  output  DATA_W  port A read data
rvalid_a  output  1  port A read data valid, 1-cycle pulse
en_b, we_b, addr_b, din_b, dout_b, rvalid_b  as port A, for port B
collision  output  1  1-cycle pulse: both ports wrote the same address in one cycle

Behaviour:
- Reset (rst=1 at edge): dout_a/b=0, rvalid_a/b=0, collision=0, pipeline flushed, FSM -> CLEAR, clear pointer=0, init_busy=1 from next cycle. Reset asserted mid-operation aborts any pending read; no rvalid for it.
- FSM CLEAR: each cycle writes 0 to mem[ptr], ptr++; after writing DEPTH-1 -> RUN; init_busy=0 from the first RUN cycle. Clear takes exactly DEPTH cycles after rst deasserts. en_a/en_b ignored in CLEAR (no write, no rvalid).
- FSM RUN: stays until rst.
- Write (en&we): mem[addr]<=din at edge. dout of that port holds previous value; rvalid=0.
- Read (en&!we): OUT_REG=0: dout=mem[addr], rvalid=1 on the cycle after request. OUT_REG=1: both appear two cycles after request. dout holds last read value when no read completes.
- en=0: port idle, no memory access, dout holds.
- Write/write same address: port A data stored, port B discarded; collision=1 next cycle (aligned with what rvalid would be for OUT_REG=0). Different addresses: both written.
- Write on one port, read same address on other: RDW_MODE=0 returns pre-write contents; RDW_MODE=1 returns the written data (bypass). No collision pulse.
- Read/read any addresses: both served, no interaction.
- Addresses cover full range; no out-of-range case.

Optional Feature:
DPRAM_PARITY_EN: defined -> each word stores one extra even-parity bit computed on write (including clear, parity of 0 = 0); adds outputs perr_a, perr_b, pulsed with rvalid when stored parity mismatches recomputed parity of read data; reset 0. Not defined -> no parity storage, no perr ports; memory is DATA_W bits wide.

Decomposition:
- Shared package dpram_pkg: FSM state typedef (ST_CLEAR, ST_RUN), RDW_OLD/RDW_NEW constants, parity function.
- One sub-module natural: dpram_out_stage (per-port dout/rvalid register plus optional OUT_REG stage, instantiated twice). Memory array, collision logic and clear FSM in top.

Test Plan:
- Reset release, DATA_W=8 ADDR_W=3: init_busy=1 for 8 cycles, then 0; read all 8 addresses on A -> dout_a=0x00 each, rvalid_a one cycle after each request.
- A writes 0x5A @3, next cycle B reads @3 -> dout_b=0x5A, rvalid_b=1 one cycle later (two with OUT_REG=1); dout_a unchanged during write.
- Same cycle A writes 0x11 @5, B writes 0x22 @5 -> collision=1 next cycle; later read @5 returns 0x11.
- mem[2]=0xAA; same cycle A writes 0x55 @2, B reads @2 -> RDW_MODE=0: dout_b=0xAA; RDW_MODE=1: dout_b=0x55; collision=0.
- Read request issued, rst asserted next cycle -> no rvalid, dout=0, clear sequence restarts, previously written data reads back 0x00.
- DPRAM_PARITY_EN: force-flip stored parity bit of word 4, read @4 -> perr_a=1 with rvalid_a; clean word -> perr_a=0.
